// File: rtl/fetch_stage.sv
// fetch_stage: sequential PC generator with one-outstanding imem req/ack and a DEPTH-entry {pc, instr} FIFO to decode.
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(DATA_W/8);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [PW:0] fill;
  logic push, pop;
  // DRAIN never pushes: its ack returns a word fetched before the last redirect.
  assign push = state == WAIT && imem_ack && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  assign out_valid = fill != '0;
  assign out_pc = pc_q[rd];
  assign out_instr = instr_q[rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      rd <= '0;
      wr <= '0;
      fill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (redirect_valid) begin
        rd <= '0;
        wr <= '0;
        fill <= '0;
        pc <= redirect_pc;
      end else begin
        if (push) begin
          pc_q[wr] <= imem_addr;
          instr_q[wr] <= imem_rdata;
          wr <= wr + 1'b1;
          pc <= pc + INC;
        end
        if (pop) rd <= rd + 1'b1;
        fill <= fill + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
      // A request is only issued from IDLE, so fill alone is the reserved count there.
      case (state)
        IDLE: if (!redirect_valid && fill < FULL) begin
          state <= WAIT;
          imem_req <= 1'b1;
          imem_addr <= pc;
        end
        WAIT, DRAIN: if (imem_ack) begin
          state <= IDLE;
          imem_req <= 1'b0;
        end else if (redirect_valid) state <= DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage sequencing, backpressure, redirects, wrap and reset.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ack, out_valid;
  logic [31:0] imem_addr, imem_rdata, out_pc, out_instr;
  logic redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic auto_en = 1'b1, ack_auto = 1'b0, ack_man = 1'b0;
  logic [31:0] rdata_auto = '0, rdata_man = '0;
  logic w_req, w_valid, w_ack = 1'b0;
  logic [31:0] w_addr, w_pc, w_instr, w_rdata = '0;
  logic [31:0] exp_pc = '0, last_ack_addr = '0, saved = '0;
  logic [31:0] w_seen [2];
  int w_n = 0;
  int checks = 0, errors = 0;

  assign imem_ack = auto_en ? ack_auto : ack_man;
  assign imem_rdata = auto_en ? rdata_auto : rdata_man;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack),
    .imem_rdata(w_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_pc), .out_instr(w_instr)
  );

  always #5 clk = ~clk;

  // Memory model: ack one cycle after the request rises, rdata = addr ^ K.
  initial forever begin
    @(posedge clk);
    #2;
    ack_auto = imem_req;
    rdata_auto = imem_addr ^ K;
    w_ack = w_req;
    w_rdata = w_addr ^ K;
  end

  always @(posedge clk) begin
    if (imem_req && imem_ack) last_ack_addr <= imem_addr;
    if (w_req && w_ack && w_n < 2) begin
      w_seen[w_n] <= w_addr;
      w_n <= w_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_words(input int n, input int budget);
    int got;
    got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("seq_pc", out_pc, exp_pc);
        check("seq_instr", out_instr, exp_pc ^ K);
        exp_pc += 4;
        got++;
      end
    end
    check("seq_count", 32'(got), 32'(n));
    @(posedge clk);
  endtask

  task automatic wait_req(input logic v, input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (imem_req !== v && c < budget);
    check("wait_req", {31'b0, imem_req}, {31'b0, v});
  endtask

  initial begin
    auto_en = 1'b0;
    ack_man = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFFFFFC);
    rst = 1'b0;
    ack_man = 1'b0;
    auto_en = 1'b1;
    out_ready = 1'b1;
    exp_pc = 32'h0;
    expect_words(6, 40);
    check("wrap_first", w_seen[0], 32'hFFFFFFFC);
    check("wrap_second", w_seen[1], 32'h0);
    // Backpressure: FIFO fills to DEPTH, then requests stop.
    @(negedge clk);
    out_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("stall_req", {31'b0, imem_req}, 32'h0);
    check("stall_valid", {31'b0, out_valid}, 32'h1);
    check("stall_head", out_pc, exp_pc);
    check("stall_depth", last_ack_addr - exp_pc, 32'h4);
    @(posedge clk);
    #1 out_ready = 1'b1;
    expect_words(4, 30);
    // Redirect while waiting; the stale ack must be dropped.
    wait_req(1'b0, 10);
    auto_en = 1'b0;
    wait_req(1'b1, 10);
    saved = imem_addr;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    check("drain_req", {31'b0, imem_req}, 32'h1);
    check("drain_addr", imem_addr, saved);
    repeat (2) @(negedge clk);
    ack_man = 1'b1;
    rdata_man = 32'hDEADBEEF;
    @(negedge clk);
    ack_man = 1'b0;
    check("drain_nopush", {31'b0, out_valid}, 32'h0);
    check("drain_done", {31'b0, imem_req}, 32'h0);
    auto_en = 1'b1;
    exp_pc = 32'h100;
    @(posedge clk);
    expect_words(3, 30);
    // Redirect, ack and pop all in one cycle.
    @(negedge clk);
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    auto_en = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_req(1'b1, 10);
    check("combo_pre_valid", {31'b0, out_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    ack_man = 1'b1;
    rdata_man = imem_addr ^ K;
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    ack_man = 1'b0;
    check("combo_valid", {31'b0, out_valid}, 32'h0);
    check("combo_req", {31'b0, imem_req}, 32'h0);
    auto_en = 1'b1;
    wait_req(1'b1, 10);
    check("combo_addr", imem_addr, 32'h200);
    exp_pc = 32'h200;
    @(posedge clk);
    expect_words(3, 30);
    // Reset mid-WAIT, then a late ack right after release.
    wait_req(1'b0, 10);
    auto_en = 1'b0;
    wait_req(1'b1, 10);
    rst = 1'b1;
    #1;
    check("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_instr", out_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_man = 1'b1;
    rdata_man = 32'h12345678;
    @(negedge clk);
    ack_man = 1'b0;
    check("late_ack_valid", {31'b0, out_valid}, 32'h0);
    check("late_ack_req", {31'b0, imem_req}, 32'h1);
    check("late_ack_addr", imem_addr, 32'h0);
    auto_en = 1'b1;
    exp_pc = 32'h0;
    @(posedge clk);
    expect_words(2, 20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
